control_step_sequencer: RTL and testbench

- Parametrised multi-cycle control unit for the bus-based datapath.
- Generates the T0..T6 control-step strobes that benches currently drive by hand: fetch, then a decoded execute for 3-register ALU ops, 2-register ALU ops, mul/div into HI/LO, mfhi/mflo, nop and halt.
- Adds a memory-ready wait state, a run/idle/halt mode and an instruction counter.
- Sits beside the datapath: reads the IR value and drives the datapath's in/out/strobe inputs.

---
 rtl/control_step_sequencer_if.sv | 51 +++++
 rtl/control_step_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_control_step_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_step_sequencer_if.sv
// Handshake and strobe bundle between the control-step sequencer and the bus datapath.
// The master modport is the sequencer side; the slave modport is the datapath or bench side.
interface control_step_sequencer_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 16
);
  logic                run;
  logic                mem_ready;
  logic [DATA_W-1:0]   ir;

  logic                pc_out;
  logic                mar_in;
  logic                inc_pc;
  logic                z_in;
  logic                z_low_out;
  logic                z_high_out;
  logic                pc_in;
  logic                read;
  logic                mdr_in;
  logic                mdr_out;
  logic                ir_in;
  logic                y_in;
  logic                lo_in;
  logic                hi_in;
  logic                lo_out;
  logic                hi_out;
  logic [NUM_REGS-1:0] reg_in;
  logic [NUM_REGS-1:0] reg_out;
  logic [4:0]          alu_op;

  logic                busy;
  logic                done;
  logic                halted;
  logic                illegal;
  logic [CNT_W-1:0]    instr_count;

  modport master (
    input  run, mem_ready, ir,
    output pc_out, mar_in, inc_pc, z_in, z_low_out, z_high_out, pc_in, read,
           mdr_in, mdr_out, ir_in, y_in, lo_in, hi_in, lo_out, hi_out,
           reg_in, reg_out, alu_op, busy, done, halted, illegal, instr_count
  );

  modport slave (
    output run, mem_ready, ir,
    input  pc_out, mar_in, inc_pc, z_in, z_low_out, z_high_out, pc_in, read,
           mdr_in, mdr_out, ir_in, y_in, lo_in, hi_in, lo_out, hi_out,
           reg_in, reg_out, alu_op, busy, done, halted, illegal, instr_count
  );
endinterface

// File: rtl/control_step_sequencer.sv
// Multi-cycle control unit: fetch, then decoded T3..T6 execute steps for the bus datapath.
// It adds a memory-ready wait in T1, run/idle/halt modes and a completed-instruction counter.
module control_step_sequencer #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     clr,
  control_step_sequencer_if.master bus
);
  localparam int REG_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALTED
  } state_e;

  typedef enum logic [2:0] {
    C_ALU3, C_MULDIV, C_UNARY, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILLEGAL
  } op_class_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [4:0]          op;
  logic [REG_W-1:0]    ra, rb, rc;
  logic [NUM_REGS-1:0] ra_hot, rb_hot, rc_hot;
  op_class_e           op_class;
  logic                fin;

  assign op     = bus.ir[DATA_W-1 -: 5];
  assign ra     = bus.ir[DATA_W-6 -: REG_W];
  assign rb     = bus.ir[DATA_W-6-REG_W -: REG_W];
  assign rc     = bus.ir[DATA_W-6-2*REG_W -: REG_W];
  assign ra_hot = NUM_REGS'(1) << ra;
  assign rb_hot = NUM_REGS'(1) << rb;
  assign rc_hot = NUM_REGS'(1) << rc;

  always_comb begin
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01000, 5'b01001, 5'b01010: op_class = C_ALU3;
      5'b01110, 5'b01111:                     op_class = C_MULDIV;
      5'b10000, 5'b10001:                     op_class = C_UNARY;
      5'b10111:                               op_class = C_MFHI;
      5'b11000:                               op_class = C_MFLO;
      5'b11001:                               op_class = C_NOP;
      5'b11010:                               op_class = C_HALT;
      default:                                op_class = C_ILLEGAL;
    endcase
  end

  // Strobes decode the registered state together with ir: the IR is only loaded at the
  // end of T2, so execute-step outputs cannot be precomputed a cycle earlier.
  always_comb begin
    bus.pc_out     = 1'b0;
    bus.mar_in     = 1'b0;
    bus.inc_pc     = 1'b0;
    bus.z_in       = 1'b0;
    bus.z_low_out  = 1'b0;
    bus.z_high_out = 1'b0;
    bus.pc_in      = 1'b0;
    bus.read       = 1'b0;
    bus.mdr_in     = 1'b0;
    bus.mdr_out    = 1'b0;
    bus.ir_in      = 1'b0;
    bus.y_in       = 1'b0;
    bus.lo_in      = 1'b0;
    bus.hi_in      = 1'b0;
    bus.lo_out     = 1'b0;
    bus.hi_out     = 1'b0;
    bus.reg_in     = '0;
    bus.reg_out    = '0;
    bus.alu_op     = '0;
    bus.illegal    = 1'b0;
    fin            = 1'b0;

    case (state_q)
      S_T0: begin
        bus.pc_out = 1'b1;
        bus.mar_in = 1'b1;
        bus.inc_pc = 1'b1;
        bus.z_in   = 1'b1;
      end
      S_T1: begin
        bus.z_low_out = 1'b1;
        bus.pc_in     = 1'b1;
        bus.read      = 1'b1;
        bus.mdr_in    = 1'b1;
      end
      S_T2: begin
        bus.mdr_out = 1'b1;
        bus.ir_in   = 1'b1;
      end
      S_T3: begin
        case (op_class)
          C_ALU3, C_MULDIV: begin
            bus.reg_out = rb_hot;
            bus.y_in    = 1'b1;
          end
          C_UNARY: begin
            bus.reg_out = rb_hot;
            bus.alu_op  = op;
            bus.z_in    = 1'b1;
          end
          C_MFHI: begin
            bus.hi_out = 1'b1;
            bus.reg_in = ra_hot;
            fin        = 1'b1;
          end
          C_MFLO: begin
            bus.lo_out = 1'b1;
            bus.reg_in = ra_hot;
            fin        = 1'b1;
          end
          C_ILLEGAL: begin
            bus.illegal = 1'b1;
            fin         = 1'b1;
          end
          default: fin = 1'b1;
        endcase
      end
      S_T4: begin
        if (op_class == C_UNARY) begin
          bus.z_low_out = 1'b1;
          bus.reg_in    = ra_hot;
          fin           = 1'b1;
        end else begin
          bus.reg_out = rc_hot;
          bus.alu_op  = op;
          bus.z_in    = 1'b1;
        end
      end
      S_T5: begin
        bus.z_low_out = 1'b1;
        if (op_class == C_MULDIV) begin
          bus.lo_in = 1'b1;
        end else begin
          bus.reg_in = ra_hot;
          fin        = 1'b1;
        end
      end
      S_T6: begin
        bus.z_high_out = 1'b1;
        bus.hi_in      = 1'b1;
        fin            = 1'b1;
      end
      default: ;
    endcase

    bus.done        = fin;
    bus.busy        = (state_q != S_IDLE) && (state_q != S_HALTED);
    bus.halted      = (state_q == S_HALTED);
    bus.instr_count = cnt_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:   state_d = bus.run ? S_T0 : S_IDLE;
      S_T0:     state_d = S_T1;
      S_T1:     state_d = bus.mem_ready ? S_T2 : S_T1;
      S_T2:     state_d = S_T3;
      S_T3:     state_d = S_T4;
      S_T4:     state_d = S_T5;
      S_T5:     state_d = S_T6;
      S_T6:     state_d = S_IDLE;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
    if (fin) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (op_class == C_HALT) begin
        state_d = S_HALTED;
      end else begin
        state_d = bus.run ? S_T0 : S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_control_step_sequencer.sv
// Scoreboard bench for control_step_sequencer: an instruction-level model queues the
// expected output bundle per cycle and a negedge monitor pops and compares it.
module tb_control_step_sequencer;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int CNT_W    = 16;

  localparam int PC_OUT = 0, MAR_IN = 1, INC_PC = 2, Z_IN = 3, Z_LOW_OUT = 4,
                 Z_HIGH_OUT = 5, PC_IN = 6, READ = 7, MDR_IN = 8, MDR_OUT = 9,
                 IR_IN = 10, Y_IN = 11, LO_IN = 12, HI_IN = 13, LO_OUT = 14, HI_OUT = 15;

  localparam int K_ALU3 = 0, K_MULDIV = 1, K_UNARY = 2, K_MFHI = 3, K_MFLO = 4,
                 K_NOP = 5, K_HALT = 6, K_ILL = 7;

  localparam logic [4:0] OP_NOP = 5'b11001;

  typedef struct packed {
    logic [15:0]         strb;
    logic [NUM_REGS-1:0] rin;
    logic [NUM_REGS-1:0] rout;
    logic [4:0]          alu;
    logic                busy;
    logic                done;
    logic                halted;
    logic                illegal;
    logic [CNT_W-1:0]    cnt;
  } obs_t;

  logic clk = 1'b0;
  logic clr;
  logic clr2;
  always #5 clk = ~clk;

  control_step_sequencer_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .CNT_W(CNT_W)) bus ();
  control_step_sequencer_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .CNT_W(2))     bus2 ();

  control_step_sequencer #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .bus(bus)
  );
  control_step_sequencer #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .CNT_W(2)) dut2 (
    .clk(clk), .clr(clr2), .bus(bus2)
  );

  obs_t             expq[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               cyc_no   = 0;
  int               m_mode;     // 0 idle, 1 running, 2 halted
  logic [CNT_W-1:0] m_cnt;

  logic [4:0] legal_ops [15] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                 5'b01000, 5'b01001, 5'b01010, 5'b01110, 5'b01111,
                                 5'b10000, 5'b10001, 5'b10111, 5'b11000, 5'b11001};

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra,
                                      input logic [3:0] rb, input logic [3:0] rc,
                                      input logic [14:0] rest);
    return {op, ra, rb, rc, rest};
  endfunction

  function automatic int cls_of(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01000, 5'b01001, 5'b01010: return K_ALU3;
      5'b01110, 5'b01111:                     return K_MULDIV;
      5'b10000, 5'b10001:                     return K_UNARY;
      5'b10111:                               return K_MFHI;
      5'b11000:                               return K_MFLO;
      5'b11001:                               return K_NOP;
      5'b11010:                               return K_HALT;
      default:                                return K_ILL;
    endcase
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a.strb    = {bus.hi_out, bus.lo_out, bus.hi_in, bus.lo_in, bus.y_in, bus.ir_in,
                 bus.mdr_out, bus.mdr_in, bus.read, bus.pc_in, bus.z_high_out,
                 bus.z_low_out, bus.z_in, bus.inc_pc, bus.mar_in, bus.pc_out};
    a.rin     = bus.reg_in;
    a.rout    = bus.reg_out;
    a.alu     = bus.alu_op;
    a.busy    = bus.busy;
    a.done    = bus.done;
    a.halted  = bus.halted;
    a.illegal = bus.illegal;
    a.cnt     = bus.instr_count;
    return a;
  endfunction

  function automatic obs_t exp_base(input bit running);
    obs_t e;
    e        = '0;
    e.busy   = running;
    e.halted = (m_mode == 2);
    e.cnt    = m_cnt;
    return e;
  endfunction

  initial begin
    forever begin
      obs_t e, a;
      @(negedge clk);
      cyc_no++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a = sample();
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle %0d outputs: actual strb=%h rin=%h rout=%h alu=%b busy=%b done=%b halted=%b illegal=%b cnt=%0d; required strb=%h rin=%h rout=%h alu=%b busy=%b done=%b halted=%b illegal=%b cnt=%0d",
                   cyc_no, a.strb, a.rin, a.rout, a.alu, a.busy, a.done, a.halted, a.illegal, a.cnt,
                   e.strb, e.rin, e.rout, e.alu, e.busy, e.done, e.halted, e.illegal, e.cnt);
        end
      end
    end
  end

  task automatic cyc(input obs_t e);
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      bus.run       = 1'b0;
      bus.mem_ready = 1'($urandom);
      cyc(exp_base(0));
    end
  endtask

  task automatic do_clr();
    clr     = 1'b1;
    bus.run = 1'b0;
    cyc(exp_base(0));
    clr    = 1'b0;
    m_mode = 0;
    m_cnt  = '0;
  endtask

  // One instruction from the current mode; clr_at >= 0 asserts clr on that execute step.
  task automatic run_instr(input logic [31:0] irv, input int unsigned waits,
                           input bit run_after, input int clr_at);
    obs_t       e;
    obs_t       steps[$];
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    int         k;
    op = irv[31:27];
    ra = irv[26:23];
    rb = irv[22:19];
    rc = irv[18:15];
    k  = cls_of(op);

    if (m_mode == 0) begin
      bus.ir        = $urandom;
      bus.run       = 1'b1;
      bus.mem_ready = 1'($urandom);
      cyc(exp_base(0));
    end
    bus.ir        = $urandom;
    bus.run       = 1'($urandom);
    bus.mem_ready = 1'($urandom);
    e = exp_base(1);
    e.strb[PC_OUT] = 1'b1; e.strb[MAR_IN] = 1'b1; e.strb[INC_PC] = 1'b1; e.strb[Z_IN] = 1'b1;
    cyc(e);
    for (int unsigned w = 0; w <= waits; w++) begin
      bus.run       = 1'($urandom);
      bus.mem_ready = (w == waits);
      e = exp_base(1);
      e.strb[Z_LOW_OUT] = 1'b1; e.strb[PC_IN] = 1'b1; e.strb[READ] = 1'b1; e.strb[MDR_IN] = 1'b1;
      cyc(e);
    end
    bus.run       = 1'($urandom);
    bus.mem_ready = 1'($urandom);
    e = exp_base(1);
    e.strb[MDR_OUT] = 1'b1; e.strb[IR_IN] = 1'b1;
    cyc(e);

    bus.ir = irv;
    case (k)
      K_ALU3, K_MULDIV: begin
        e = exp_base(1); e.rout[rb] = 1'b1; e.strb[Y_IN] = 1'b1; steps.push_back(e);
        e = exp_base(1); e.rout[rc] = 1'b1; e.alu = op; e.strb[Z_IN] = 1'b1; steps.push_back(e);
        e = exp_base(1); e.strb[Z_LOW_OUT] = 1'b1;
        if (k == K_ALU3) e.rin[ra] = 1'b1; else e.strb[LO_IN] = 1'b1;
        steps.push_back(e);
        if (k == K_MULDIV) begin
          e = exp_base(1); e.strb[Z_HIGH_OUT] = 1'b1; e.strb[HI_IN] = 1'b1; steps.push_back(e);
        end
      end
      K_UNARY: begin
        e = exp_base(1); e.rout[rb] = 1'b1; e.alu = op; e.strb[Z_IN] = 1'b1; steps.push_back(e);
        e = exp_base(1); e.strb[Z_LOW_OUT] = 1'b1; e.rin[ra] = 1'b1; steps.push_back(e);
      end
      K_MFHI: begin
        e = exp_base(1); e.strb[HI_OUT] = 1'b1; e.rin[ra] = 1'b1; steps.push_back(e);
      end
      K_MFLO: begin
        e = exp_base(1); e.strb[LO_OUT] = 1'b1; e.rin[ra] = 1'b1; steps.push_back(e);
      end
      K_ILL: begin
        e = exp_base(1); e.illegal = 1'b1; steps.push_back(e);
      end
      default: begin
        e = exp_base(1); steps.push_back(e);
      end
    endcase
    e = steps.pop_back();
    e.done = 1'b1;
    steps.push_back(e);

    for (int i = 0; i < steps.size(); i++) begin
      bus.run       = (i == steps.size() - 1) ? run_after : 1'($urandom);
      bus.mem_ready = 1'($urandom);
      if (i == clr_at) begin
        clr     = 1'b1;
        bus.run = 1'b0;
        cyc(steps[i]);
        clr    = 1'b0;
        m_mode = 0;
        m_cnt  = '0;
        return;
      end
      cyc(steps[i]);
    end
    m_cnt++;
    m_mode = (k == K_HALT) ? 2 : (run_after ? 1 : 0);
  endtask

  initial begin
    logic [1:0] exp2 [5];
    exp2 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    clr  = 1'b1;
    clr2 = 1'b1;
    bus.run = 1'b0;  bus.mem_ready = 1'b0;  bus.ir = '0;
    bus2.run = 1'b0; bus2.mem_ready = 1'b1; bus2.ir = enc(OP_NOP, 4'd0, 4'd0, 4'd0, 15'd0);
    @(posedge clk);
    #1;
    m_mode = 0;
    m_cnt  = '0;
    cyc(exp_base(0));
    clr = 1'b0;
    idle(5);

    run_instr(enc(5'b01111, 4'd0, 4'd6, 4'd7, 15'd0), 0, 1'b0, -1);
    run_instr(enc(5'b00011, 4'd3, 4'd1, 4'd2, 15'd0), 3, 1'b0, -1);
    idle(1);

    for (int n = 0; n < 60; n++) begin
      int unsigned r;
      logic [4:0]  op;
      bit          ra_after;
      r = $urandom_range(0, 19);
      op = (r < 15) ? legal_ops[r] : 5'($urandom);
      if (op == 5'b11010) op = 5'b11111;
      ra_after = ($urandom_range(0, 3) != 0);
      run_instr(enc(op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)),
                $urandom_range(0, 3), ra_after, -1);
      if (!ra_after) idle($urandom_range(0, 2));
    end
    run_instr(enc(OP_NOP, 4'd0, 4'd0, 4'd0, 15'd0), 0, 1'b0, -1);

    do_clr();
    run_instr(enc(5'b01110, 4'd2, 4'd3, 4'd4, 15'd0), 1, 1'b1, 1);
    idle(3);

    run_instr(enc(5'b11000, 4'd5, 4'd0, 4'd0, 15'd0), 0, 1'b1, -1);
    run_instr(enc(5'b10001, 4'd4, 4'd9, 4'd0, 15'd0), 2, 1'b1, -1);
    run_instr(enc(5'b11111, 4'd1, 4'd2, 4'd3, 15'd0), 0, 1'b1, -1);
    run_instr(enc(5'b11010, 4'd0, 4'd0, 4'd0, 15'd0), 1, 1'b1, -1);
    for (int i = 0; i < 5; i++) begin
      bus.run       = 1'b1;
      bus.mem_ready = 1'($urandom);
      cyc(exp_base(0));
    end
    do_clr();
    idle(2);

    clr2     = 1'b0;
    bus2.run = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus2.instr_count !== 2'd0) begin
      n_fail++;
      $display("FAIL cnt2_start: actual %0d required 0", bus2.instr_count);
    end
    for (int i = 0; i < 5; i++) begin
      int k;
      k = 0;
      while (bus2.done !== 1'b1 && k < 30) begin
        @(negedge clk);
        k++;
      end
      n_checks++;
      if (bus2.done !== 1'b1) begin
        n_fail++;
        $display("FAIL cnt2_done_%0d: actual no done within 30 cycles required done pulse", i);
      end else begin
        @(negedge clk);
        if (bus2.instr_count !== exp2[i]) begin
          n_fail++;
          $display("FAIL cnt2_wrap_%0d: actual %0d required %0d", i, bus2.instr_count, exp2[i]);
        end
      end
    end

    @(posedge clk);
    #1;
    n_checks++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: actual %0d pending required 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
